nerv_wb_bridge: RTL and testbench

- Parametrised bridge between a NERV-style fixed-latency core memory interface and two Wishbone-classic-style buses: instruction and data.
- The core expects read data one cycle after presenting an address. The bridge stalls the core until both bus channels complete.
- Adds byte-strobe writes, ack timeout with error reporting, and a stall-cycle counter.
- Sits inside processorci_top between the core and the Controller buses.

---
 rtl/nerv_wb_bridge.sv | 173 +++++++++++++++++
 tb/tb_nerv_wb_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nerv_wb_bridge.sv
// Bridge from a NERV-style fixed-latency core memory port to separate Wishbone-classic
// instruction and data buses, with per-channel ack timeout and a stall-cycle counter.
//
// state | meaning
// PRIME | reset-only; forces a capture on the first cycle out of reset
// BUS   | request in flight on this channel's bus
// HOLD  | result latched, waiting for the other channel
module nerv_wb_bridge #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    TIMEOUT_CYCLES  = 255,
    parameter logic [DATA_WIDTH-1:0] IFETCH_ERR_WORD = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    output logic                    core_stall,
    input  logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic [DATA_WIDTH-1:0]   imem_data,
    input  logic                    dmem_valid,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    core_cyc,
    output logic                    core_stb,
    output logic                    core_we,
    output logic [DATA_WIDTH/8-1:0] core_wstrb,
    output logic [ADDR_WIDTH-1:0]   core_addr,
    output logic [DATA_WIDTH-1:0]   core_data_out,
    input  logic [DATA_WIDTH-1:0]   core_data_in,
    input  logic                    core_ack,
    output logic                    data_mem_cyc,
    output logic                    data_mem_stb,
    output logic                    data_mem_we,
    output logic [DATA_WIDTH/8-1:0] data_mem_wstrb,
    output logic [ADDR_WIDTH-1:0]   data_mem_addr,
    output logic [DATA_WIDTH-1:0]   data_mem_data_out,
    input  logic [DATA_WIDTH-1:0]   data_mem_data_in,
    input  logic                    data_mem_ack,
    output logic                    bus_error,
    output logic [31:0]             stall_count
);
    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        BUS   = 2'd1,
        HOLD  = 2'd2
    } ch_state_t;

    ch_state_t               i_st_q, i_st_d, d_st_q, d_st_d;
    logic [ADDR_WIDTH-1:0]   i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [DATA_WIDTH/8-1:0] d_wstrb_q, d_wstrb_d;
    logic [DATA_WIDTH-1:0]   d_wdata_q, d_wdata_d;
    logic [DATA_WIDTH-1:0]   imem_data_q, imem_data_d, dmem_rdata_q, dmem_rdata_d;
    logic [TW-1:0]           i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic                    bus_error_q, bus_error_d;
    logic [31:0]             stall_count_q, stall_count_d;
    logic                    capture, i_to, d_to;

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            i_st_q        <= PRIME;
            d_st_q        <= PRIME;
            i_addr_q      <= '0;
            d_addr_q      <= '0;
            d_wstrb_q     <= '0;
            d_wdata_q     <= '0;
            imem_data_q   <= IFETCH_ERR_WORD;
            dmem_rdata_q  <= '0;
            i_cnt_q       <= '0;
            d_cnt_q       <= '0;
            bus_error_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            i_st_q        <= i_st_d;
            d_st_q        <= d_st_d;
            i_addr_q      <= i_addr_d;
            d_addr_q      <= d_addr_d;
            d_wstrb_q     <= d_wstrb_d;
            d_wdata_q     <= d_wdata_d;
            imem_data_q   <= imem_data_d;
            dmem_rdata_q  <= dmem_rdata_d;
            i_cnt_q       <= i_cnt_d;
            d_cnt_q       <= d_cnt_d;
            bus_error_q   <= bus_error_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        i_st_d        = i_st_q;
        d_st_d        = d_st_q;
        i_addr_d      = i_addr_q;
        d_addr_d      = d_addr_q;
        d_wstrb_d     = d_wstrb_q;
        d_wdata_d     = d_wdata_q;
        imem_data_d   = imem_data_q;
        dmem_rdata_d  = dmem_rdata_q;
        i_cnt_d       = i_cnt_q;
        d_cnt_d       = d_cnt_q;
        i_to          = 1'b0;
        d_to          = 1'b0;
        stall_count_d = core_stall ? stall_count_q + 32'd1 : stall_count_q;

        // A channel never sits in BUS while a capture is pending, so BUS takes priority.
        capture = (i_st_q == PRIME) || (d_st_q == PRIME) ||
                  ((i_st_q == HOLD) && (d_st_q == HOLD));

        if (i_st_q == BUS) begin
            i_cnt_d = i_cnt_q + TW'(1);
            if (core_ack) begin
                imem_data_d = core_data_in;
                i_st_d      = HOLD;
            end else if (TO_EN && (i_cnt_q == TO_LAST)) begin
                i_to        = 1'b1;
                imem_data_d = IFETCH_ERR_WORD;
                i_st_d      = HOLD;
            end
        end else if (capture) begin
            i_addr_d = imem_addr;
            i_cnt_d  = '0;
            i_st_d   = BUS;
        end

        if (d_st_q == BUS) begin
            d_cnt_d = d_cnt_q + TW'(1);
            if (data_mem_ack) begin
                if (d_wstrb_q == '0) dmem_rdata_d = data_mem_data_in;
                d_st_d = HOLD;
            end else if (TO_EN && (d_cnt_q == TO_LAST)) begin
                // A timed-out write is simply dropped; a timed-out read returns zero.
                d_to = 1'b1;
                if (d_wstrb_q == '0) dmem_rdata_d = '0;
                d_st_d = HOLD;
            end
        end else if (capture) begin
            if (dmem_valid) begin
                d_addr_d  = dmem_addr;
                d_wstrb_d = dmem_wstrb;
                d_wdata_d = dmem_wdata;
                d_cnt_d   = '0;
                d_st_d    = BUS;
            end else begin
                d_st_d = HOLD;
            end
        end

        bus_error_d = i_to | d_to;
    end

    assign core_stall        = !((i_st_q == HOLD) && (d_st_q == HOLD));
    assign imem_data         = imem_data_q;
    assign dmem_rdata        = dmem_rdata_q;
    assign bus_error         = bus_error_q;
    assign stall_count       = stall_count_q;

    assign core_cyc          = (i_st_q == BUS);
    assign core_stb          = (i_st_q == BUS);
    assign core_we           = 1'b0;
    assign core_wstrb        = '0;
    assign core_addr         = i_addr_q;
    assign core_data_out     = '0;

    assign data_mem_cyc      = (d_st_q == BUS);
    assign data_mem_stb      = (d_st_q == BUS);
    assign data_mem_we       = (d_st_q == BUS) && (|d_wstrb_q);
    assign data_mem_wstrb    = (d_st_q == BUS) ? d_wstrb_q : '0;
    assign data_mem_addr     = d_addr_q;
    assign data_mem_data_out = d_wdata_q;
endmodule

// File: tb/tb_nerv_wb_bridge.sv
// Directed bench for nerv_wb_bridge: one instance with a short timeout, one with timeout disabled,
// both driven by the same stimulus; expected read results flow through a scoreboard queue.
module tb_nerv_wb_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, core_data_in, data_mem_data_in;
    logic        dmem_valid, core_ack, data_mem_ack;
    logic [3:0]  dmem_wstrb;

    logic        a_stall, a_ccyc, a_cstb, a_cwe, a_dcyc, a_dstb, a_dwe, a_err;
    logic [3:0]  a_cwstrb, a_dwstrb;
    logic [31:0] a_caddr, a_cdout, a_imem, a_dmem, a_daddr, a_ddout, a_sc;
    logic        b_stall, b_ccyc, b_cstb, b_cwe, b_dcyc, b_dstb, b_dwe, b_err;
    logic [3:0]  b_cwstrb, b_dwstrb;
    logic [31:0] b_caddr, b_cdout, b_imem, b_dmem, b_daddr, b_ddout, b_sc;

    nerv_wb_bridge #(.TIMEOUT_CYCLES(4)) dut_a (
        .clk_core(clk), .rst_core(rst), .core_stall(a_stall),
        .imem_addr(imem_addr), .imem_data(a_imem),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(a_dmem),
        .core_cyc(a_ccyc), .core_stb(a_cstb), .core_we(a_cwe), .core_wstrb(a_cwstrb),
        .core_addr(a_caddr), .core_data_out(a_cdout), .core_data_in(core_data_in),
        .core_ack(core_ack),
        .data_mem_cyc(a_dcyc), .data_mem_stb(a_dstb), .data_mem_we(a_dwe),
        .data_mem_wstrb(a_dwstrb), .data_mem_addr(a_daddr), .data_mem_data_out(a_ddout),
        .data_mem_data_in(data_mem_data_in), .data_mem_ack(data_mem_ack),
        .bus_error(a_err), .stall_count(a_sc)
    );

    nerv_wb_bridge #(.TIMEOUT_CYCLES(0)) dut_b (
        .clk_core(clk), .rst_core(rst), .core_stall(b_stall),
        .imem_addr(imem_addr), .imem_data(b_imem),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(b_dmem),
        .core_cyc(b_ccyc), .core_stb(b_cstb), .core_we(b_cwe), .core_wstrb(b_cwstrb),
        .core_addr(b_caddr), .core_data_out(b_cdout), .core_data_in(core_data_in),
        .core_ack(core_ack),
        .data_mem_cyc(b_dcyc), .data_mem_stb(b_dstb), .data_mem_we(b_dwe),
        .data_mem_wstrb(b_dwstrb), .data_mem_addr(b_daddr), .data_mem_data_out(b_ddout),
        .data_mem_data_in(data_mem_data_in), .data_mem_ack(data_mem_ack),
        .bus_error(b_err), .stall_count(b_sc)
    );

    logic        sel;
    int          cur_to;
    logic        s_stall, s_ccyc, s_dcyc, s_err;
    logic [31:0] s_imem, s_dmem, s_sc;
    assign s_stall = sel ? b_stall : a_stall;
    assign s_ccyc  = sel ? b_ccyc  : a_ccyc;
    assign s_dcyc  = sel ? b_dcyc  : a_dcyc;
    assign s_err   = sel ? b_err   : a_err;
    assign s_imem  = sel ? b_imem  : a_imem;
    assign s_dmem  = sel ? b_dmem  : a_dmem;
    assign s_sc    = sel ? b_sc    : a_sc;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        core_ack     = 1'b0;
        data_mem_ack = 1'b0;
        model_rdata  = '0;
        tick();
        chk("rst_stall", s_stall, 1);
        chk("rst_ccyc", s_ccyc, 0);
        chk("rst_cstb", a_cstb, 0);
        chk("rst_dcyc", s_dcyc, 0);
        chk("rst_dstb", a_dstb, 0);
        chk("rst_dwe", a_dwe, 0);
        chk("rst_dwstrb", a_dwstrb, 0);
        chk("rst_caddr", a_caddr, 0);
        chk("rst_daddr", a_daddr, 0);
        chk("rst_ddout", a_ddout, 0);
        chk("rst_imem", s_imem, 32'h0000_0013);
        chk("rst_dmem", s_dmem, 0);
        chk("rst_err", s_err, 0);
        chk("rst_sc", s_sc, 0);
        chk("rst_b_ctrl", {b_cstb, b_cwe, b_cwstrb, b_dstb, b_dwe, b_dwstrb}, 0);
        chk("rst_b_bus", b_caddr | b_cdout | b_daddr | b_ddout, 0);
    endtask

    // Issue one I fetch plus an optional D access from a capture-ready (or reset) state.
    // idly/ddly: BUS cycle index (0 = first) on which the ack is driven; negative = never.
    task automatic access(input string tag, input logic [31:0] ia, input logic [31:0] idat,
                          input int idly, input logic dv, input logic [3:0] ds,
                          input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] drd,
                          input int ddly, input logic stray);
        int          end_i, end_d, exp_k, done_k, prime;
        logic        ti, td;
        logic [31:0] sc0;
        exp_t        e, got;
        ti    = (cur_to != 0) && (idly < 0 || idly >= cur_to);
        end_i = ti ? cur_to - 1 : idly;
        td    = dv && (cur_to != 0) && (ddly < 0 || ddly >= cur_to);
        end_d = !dv ? -1 : (td ? cur_to - 1 : ddly);
        exp_k = (end_i > end_d) ? end_i : end_d;
        e.i   = ti ? 32'h0000_0013 : idat;
        if (dv && ds == 4'b0) model_rdata = td ? 32'h0 : drd;
        e.d = model_rdata;
        sb.push_back(e);
        prime = int'(rst);
        sc0   = s_sc;

        rst              = 1'b0;
        imem_addr        = ia;
        dmem_valid       = dv;
        dmem_wstrb       = ds;
        dmem_addr        = da;
        dmem_wdata       = dwd;
        core_data_in     = idat;
        data_mem_data_in = drd;
        core_ack         = stray;
        data_mem_ack     = stray;
        tick();
        core_ack     = 1'b0;
        data_mem_ack = 1'b0;

        chk({tag, "_caddr"}, a_caddr, ia);
        chk({tag, "_ccyc0"}, {a_ccyc, a_cstb}, 2'b11);
        chk({tag, "_cwr0"}, {a_cwe, a_cwstrb}, 0);
        chk({tag, "_cdout0"}, a_cdout, 0);
        chk({tag, "_dcyc0"}, {a_dcyc, a_dstb}, {dv, dv});
        chk({tag, "_err0"}, s_err, 0);
        if (dv) begin
            chk({tag, "_daddr"}, a_daddr, da);
            chk({tag, "_dwe"}, a_dwe, |ds);
            chk({tag, "_dwstrb"}, a_dwstrb, ds);
            chk({tag, "_ddout"}, a_ddout, dwd);
        end

        done_k = -1;
        for (int k = 0; k < 1100; k++) begin
            core_ack     = (k == idly);
            data_mem_ack = dv && (k == ddly);
            tick();
            core_ack     = 1'b0;
            data_mem_ack = 1'b0;
            chk({tag, "_ccyc"}, s_ccyc, k < end_i);
            chk({tag, "_dcyc"}, s_dcyc, dv && (k < end_d));
            chk({tag, "_err"}, s_err, (ti && k == end_i) || (td && k == end_d));
            if (!s_stall) begin
                done_k = k;
                break;
            end
        end
        chk({tag, "_release_cycle"}, done_k, exp_k);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            got = sb.pop_front();
            chk({tag, "_imem"}, s_imem, got.i);
            chk({tag, "_dmem"}, s_dmem, got.d);
        end
        chk({tag, "_stall_delta"}, s_sc - sc0, 32'(exp_k + 1 + prime));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; cur_to = 4;
        imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0; dmem_valid = 1'b0;
        core_data_in = '0; data_mem_data_in = '0; core_ack = 1'b0; data_mem_ack = 1'b0;
        rst = 1'b1;
        do_reset();
        tick();

        access("fetch", 32'h100, 32'h0050_0093, 0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        access("dread", 32'h104, 32'h0010_0113, 2, 1'b1, 4'b0, 32'h3000, 32'h0, 32'h1234_5678, 2, 1'b0);
        access("dwrite", 32'h108, 32'h0020_0193, 1, 1'b1, 4'b0110, 32'h2004, 32'hAABB_CCDD,
               32'hDEAD_BEEF, 3, 1'b0);
        access("min", 32'h10C, 32'h0030_0213, 0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        access("i_to", 32'h110, 32'hFFFF_FFFF, -1, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        access("ack_wins", 32'h114, 32'h0040_0293, 3, 1'b1, 4'b0, 32'h3004, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
        access("d_rd_to", 32'h118, 32'h0050_0313, 0, 1'b1, 4'b0, 32'h3008, 32'h0, 32'h9999_9999, -1, 1'b0);
        access("both_to", 32'h11C, 32'hEEEE_EEEE, -1, 1'b1, 4'b0, 32'h300C, 32'h0, 32'h8888_8888, -1, 1'b0);
        access("dread2", 32'h120, 32'h0060_0393, 1, 1'b1, 4'b0, 32'h3010, 32'h0, 32'h5A5A_0F0F, 0, 1'b0);
        access("d_wr_to", 32'h124, 32'h0070_0413, 0, 1'b1, 4'b1111, 32'h3014, 32'h0102_0304,
               32'h7777_7777, -1, 1'b0);

        imem_addr  = 32'h200;
        dmem_valid = 1'b1;
        dmem_wstrb = 4'b0;
        dmem_addr  = 32'h3300;
        tick();
        tick();
        chk("midtx_dcyc_before", a_dcyc, 1);
        do_reset();
        access("restart", 32'h400, 32'h00C0_0193, 1, 1'b1, 4'b0, 32'h3300, 32'h0, 32'h77, 0, 1'b1);

        sel = 1'b1; cur_to = 0;
        do_reset();
        access("no_to", 32'h500, 32'h1111_1111, 1000, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        chk("stall_ge_1000", s_sc >= 32'd1000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
